ecc_host_link: RTL and testbench
================================

# ecc_host_link

Host-side serial link partner for the ECC point-multiplication wrapper. It takes parallel operands and drives the wrapper's bit-serial input protocol: a start pulse, the 2-bit mode, the P/a/b/prime/m frame, and later the nP frame, all MSB first. It also deserializes the wrapper's mP and mnP serial result streams back into parallel words. It sits between a bus or test host and the wrapper, one instance per wrapper.

## Interface
Parameters:
- MAX_BITS, 256, width of parallel operand/result words
- NP_GAP, 4, idle cycles (≥1) between last P-frame bit and the nP valid pulse

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  request a transaction, sampled only when ready=1
- mode  in  2  operand length select: 0→L=32, 1→L=64, 2→L=128, 3→L=256
- a, b, prime, Px, Py, m, nPx, nPy  in  MAX_BITS each  parallel operands, bits [L-1:0] used
- ready  out  1  high in IDLE only
- o_m_P_valid, o_nP_valid  out  1  single-cycle frame-start pulses to wrapper
- o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy  out  1  serial data to wrapper
- i_mP_valid, i_mnP_valid  in  1  result-stream valids from wrapper
- i_mPx, i_mPy, i_mnPx, i_mnPy  in  1  serial results, MSB on first valid cycle
- mPx, mPy, mnPx, mnPy  out  MAX_BITS  deserialized results, right-aligned, upper bits 0
- mP_done, mnP_done  out  1  one-cycle pulse when the corresponding result word is complete
- err  out  1  sticky protocol error, cleared by the next accepted start

## Operation
- Start accept: start && ready latches all operands and mode into shadow registers, computes L = 32<<mode, clears mPx/mPy/mnPx/mnPy and err.
- TX FSM: IDLE → HDR → MODE → DATA → GAP → NP_HDR → NP_DATA → WAIT_RES → IDLE.
- HDR (1 cycle): o_m_P_valid=1.
- MODE (2 cycles): o_mode = mode[1], then mode[0].
- DATA (L cycles): on cycle k=0..L-1, o_Px/o_Py/o_m/o_a/o_b/o_prime each carry operand bit [L-1-k].
- GAP: NP_GAP cycles, all serial outputs 0.
- NP_HDR (1 cycle): o_nP_valid=1.
- NP_DATA (L cycles): o_nPx/o_nPy carry bit [L-1-k].
- WAIT_RES: hold until both mP_done and mnP_done have occurred in this transaction, then return to IDLE.
- Every serial data output is 0 outside its own sending state.
- start is ignored whenever ready=0.
- RX mP and RX mnP are two independent receivers, active from start accept until IDLE.
  - Each cycle its valid is high: shift left into the result pair (x and y together) and increment its bit count.
  - When the count reaches L on a valid cycle, pulse done on the next cycle and stop accepting.
- Errors; err is set and the transaction still completes normally:
  - valid falls with 0 < count < L (receiver resets its count and keeps listening),
  - valid high after the receiver has completed,
  - any valid high while in IDLE.
- Result arrival order is free. mP may arrive before nP is sent, and both receivers may be active in the same cycle.
- Reset mid-transaction: state → IDLE, all counters 0, results 0, serial outputs 0. A wrapper stream already in flight is then flagged only by the IDLE-valid rule (err=1).

## Timing
- Reset values: ready=1; all other outputs 0.
- Latency from start accepted at cycle t:
  - o_m_P_valid at t+1,
  - mode bits at t+2 and t+3,
  - data bits at t+4 … t+3+L,
  - o_nP_valid at t+4+L+NP_GAP,
  - nP bits at t+5+L+NP_GAP … t+4+2L+NP_GAP.
- Result with first valid at cycle r: last bit sampled at r+L-1, result registers final and done pulsed at r+L.
- ready returns high the cycle after the later of the two done pulses, or 2L+NP_GAP+5 cycles after t if both results arrived before NP_DATA ended.
- All outputs are registered except ready, which is decoded from the state register.

## Test plan
- mode=0, Px=0x8000_0001, Py=0x5, m=0xF, a=2, b=3, prime=97, NP_GAP=4. Required: o_m_P_valid at t+1; o_mode=0,0 at t+2 and t+3; o_Px=1 at t+4, 0 for t+5 … t+34, 1 at t+35; o_nP_valid at t+40.
- mode=3, nPx=all-ones. Required: o_nPx=1 for exactly 256 consecutive cycles starting t+265.
- Wrapper model returns mPx=0x1234_5678, mPy=0xCAFE_BABE in mode 0, then mnP 20 cycles later. Required: mP_done with mPx=0x12345678 and mPy=0xCAFEBABE; mnP_done follows; ready=1 the next cycle.
- Short frame: i_mP_valid high for 10 cycles in mode 0. Required: err=1, no mP_done; a correct retransmit then produces mP_done.
- mP and mnP streams fully overlapping. Required: both words correct and both done pulses in the same cycle.
- rst asserted mid-DATA. Required: next cycle ready=1 and all serial outputs 0; a new start runs a clean transaction.

Source files
------------

// File: rtl/ecc_host_link.sv
// Host-side link partner for the ECC point-multiplication wrapper.
// Serializes operand frames (P/a/b/prime/m, then nP) MSB first and
// deserializes the mP and mnP result streams back into parallel words.
module ecc_host_link #(
  parameter int MAX_BITS = 256,
  parameter int NP_GAP   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [MAX_BITS-1:0] a,
  input  logic [MAX_BITS-1:0] b,
  input  logic [MAX_BITS-1:0] prime,
  input  logic [MAX_BITS-1:0] Px,
  input  logic [MAX_BITS-1:0] Py,
  input  logic [MAX_BITS-1:0] m,
  input  logic [MAX_BITS-1:0] nPx,
  input  logic [MAX_BITS-1:0] nPy,
  output logic                ready,
  output logic                o_m_P_valid,
  output logic                o_nP_valid,
  output logic                o_mode,
  output logic                o_a,
  output logic                o_b,
  output logic                o_prime,
  output logic                o_Px,
  output logic                o_Py,
  output logic                o_m,
  output logic                o_nPx,
  output logic                o_nPy,
  input  logic                i_mP_valid,
  input  logic                i_mnP_valid,
  input  logic                i_mPx,
  input  logic                i_mPy,
  input  logic                i_mnPx,
  input  logic                i_mnPy,
  output logic [MAX_BITS-1:0] mPx,
  output logic [MAX_BITS-1:0] mPy,
  output logic [MAX_BITS-1:0] mnPx,
  output logic [MAX_BITS-1:0] mnPy,
  output logic                mP_done,
  output logic                mnP_done,
  output logic                err
);

  localparam int CW = $clog2(MAX_BITS) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_MODE, S_DATA, S_GAP, S_NP_HDR, S_NP_DATA, S_WAIT_RES
  } state_t;

  state_t state, state_next;
  logic [CW-1:0] cnt, len, shamt;
  logic [1:0] mode_q;
  logic [MAX_BITS-1:0] sh_a, sh_b, sh_prime, sh_px, sh_py, sh_m, sh_npx, sh_npy;
  logic accept;
  logic [CW-1:0] mp_cnt, mnp_cnt;
  logic mp_complete, mp_pend, mp_seen, mp_err;
  logic mnp_complete, mnp_pend, mnp_seen, mnp_err;

  assign ready  = (state == S_IDLE);
  assign accept = start && (state == S_IDLE);
  assign shamt  = CW'(MAX_BITS) - (CW'(32) << mode);

  // Next-state decode; the shared counter times each multi-cycle state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start) state_next = S_HDR;
      S_HDR:      state_next = S_MODE;
      S_MODE:     if (cnt == CW'(1)) state_next = S_DATA;
      S_DATA:     if (cnt == len - CW'(1)) state_next = S_GAP;
      S_GAP:      if (cnt == CW'(NP_GAP - 1)) state_next = S_NP_HDR;
      S_NP_HDR:   state_next = S_NP_DATA;
      S_NP_DATA:  if (cnt == len - CW'(1)) state_next = S_WAIT_RES;
      S_WAIT_RES: if ((mp_seen || mP_done) && (mnp_seen || mnP_done)) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // State register with a per-state cycle counter that restarts on every transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? '0 : cnt + CW'(1);
    end
  end

  // Operand shadows are left-aligned on accept so the MSB always carries the next bit;
  // serial outputs are registered from the current state, hence one cycle behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;  len <= '0;
      sh_a <= '0;  sh_b <= '0;  sh_prime <= '0;  sh_px <= '0;
      sh_py <= '0; sh_m <= '0;  sh_npx <= '0;    sh_npy <= '0;
      o_m_P_valid <= 1'b0; o_nP_valid <= 1'b0; o_mode <= 1'b0;
      o_a <= 1'b0; o_b <= 1'b0; o_prime <= 1'b0; o_Px <= 1'b0;
      o_Py <= 1'b0; o_m <= 1'b0; o_nPx <= 1'b0; o_nPy <= 1'b0;
    end else begin
      if (accept) begin
        mode_q   <= mode;
        len      <= CW'(32) << mode;
        sh_a     <= a << shamt;
        sh_b     <= b << shamt;
        sh_prime <= prime << shamt;
        sh_px    <= Px << shamt;
        sh_py    <= Py << shamt;
        sh_m     <= m << shamt;
        sh_npx   <= nPx << shamt;
        sh_npy   <= nPy << shamt;
      end else if (state == S_DATA) begin
        sh_a     <= {sh_a[MAX_BITS-2:0], 1'b0};
        sh_b     <= {sh_b[MAX_BITS-2:0], 1'b0};
        sh_prime <= {sh_prime[MAX_BITS-2:0], 1'b0};
        sh_px    <= {sh_px[MAX_BITS-2:0], 1'b0};
        sh_py    <= {sh_py[MAX_BITS-2:0], 1'b0};
        sh_m     <= {sh_m[MAX_BITS-2:0], 1'b0};
      end else if (state == S_NP_DATA) begin
        sh_npx   <= {sh_npx[MAX_BITS-2:0], 1'b0};
        sh_npy   <= {sh_npy[MAX_BITS-2:0], 1'b0};
      end
      o_m_P_valid <= (state == S_HDR);
      o_nP_valid  <= (state == S_NP_HDR);
      o_mode      <= (state == S_MODE) && ((cnt == '0) ? mode_q[1] : mode_q[0]);
      o_a         <= (state == S_DATA) && sh_a[MAX_BITS-1];
      o_b         <= (state == S_DATA) && sh_b[MAX_BITS-1];
      o_prime     <= (state == S_DATA) && sh_prime[MAX_BITS-1];
      o_Px        <= (state == S_DATA) && sh_px[MAX_BITS-1];
      o_Py        <= (state == S_DATA) && sh_py[MAX_BITS-1];
      o_m         <= (state == S_DATA) && sh_m[MAX_BITS-1];
      o_nPx       <= (state == S_NP_DATA) && sh_npx[MAX_BITS-1];
      o_nPy       <= (state == S_NP_DATA) && sh_npy[MAX_BITS-1];
    end
  end

  // mP receiver: shifts while valid, flags done one cycle after the L-th bit
  always_ff @(posedge clk) begin
    if (rst) begin
      mp_cnt <= '0; mp_complete <= 1'b0; mp_pend <= 1'b0; mp_seen <= 1'b0;
      mPx <= '0; mPy <= '0; mP_done <= 1'b0;
    end else begin
      mP_done <= mp_pend;
      mp_pend <= 1'b0;
      if (mP_done) mp_seen <= 1'b1;
      if (accept) begin
        mp_cnt <= '0; mp_complete <= 1'b0; mp_pend <= 1'b0; mp_seen <= 1'b0;
        mPx <= '0; mPy <= '0; mP_done <= 1'b0;
      end else if (state != S_IDLE && !mp_complete) begin
        if (i_mP_valid) begin
          mPx    <= {mPx[MAX_BITS-2:0], i_mPx};
          mPy    <= {mPy[MAX_BITS-2:0], i_mPy};
          mp_cnt <= mp_cnt + CW'(1);
          if (mp_cnt + CW'(1) == len) begin
            mp_complete <= 1'b1;
            mp_pend     <= 1'b1;
          end
        end else if (mp_cnt != '0) begin
          mp_cnt <= '0; mPx <= '0; mPy <= '0;
        end
      end
    end
  end

  // mnP receiver: same behaviour as the mP receiver, fully independent of it
  always_ff @(posedge clk) begin
    if (rst) begin
      mnp_cnt <= '0; mnp_complete <= 1'b0; mnp_pend <= 1'b0; mnp_seen <= 1'b0;
      mnPx <= '0; mnPy <= '0; mnP_done <= 1'b0;
    end else begin
      mnP_done <= mnp_pend;
      mnp_pend <= 1'b0;
      if (mnP_done) mnp_seen <= 1'b1;
      if (accept) begin
        mnp_cnt <= '0; mnp_complete <= 1'b0; mnp_pend <= 1'b0; mnp_seen <= 1'b0;
        mnPx <= '0; mnPy <= '0; mnP_done <= 1'b0;
      end else if (state != S_IDLE && !mnp_complete) begin
        if (i_mnP_valid) begin
          mnPx    <= {mnPx[MAX_BITS-2:0], i_mnPx};
          mnPy    <= {mnPy[MAX_BITS-2:0], i_mnPy};
          mnp_cnt <= mnp_cnt + CW'(1);
          if (mnp_cnt + CW'(1) == len) begin
            mnp_complete <= 1'b1;
            mnp_pend     <= 1'b1;
          end
        end else if (mnp_cnt != '0) begin
          mnp_cnt <= '0; mnPx <= '0; mnPy <= '0;
        end
      end
    end
  end

  // Protocol violations: valid in IDLE, valid after completion, or a truncated frame
  always_comb begin
    mp_err  = 1'b0;
    mnp_err = 1'b0;
    if (state == S_IDLE) begin
      mp_err  = i_mP_valid;
      mnp_err = i_mnP_valid;
    end else begin
      mp_err  = mp_complete  ? i_mP_valid  : (!i_mP_valid  && mp_cnt  != '0);
      mnp_err = mnp_complete ? i_mnP_valid : (!i_mnP_valid && mnp_cnt != '0);
    end
  end

  // Sticky error flag, cleared only by the next accepted start
  always_ff @(posedge clk) begin
    if (rst)                   err <= 1'b0;
    else if (accept)           err <= 1'b0;
    else if (mp_err || mnp_err) err <= 1'b1;
  end

endmodule

// File: tb/tb_ecc_host_link.sv
// Directed bench for ecc_host_link: vector table for the mode-0 frame timing,
// hand-written sequences for results, short frames, reset and mode 3.
module tb_ecc_host_link;

  localparam int MB = 256;
  localparam int SIG_MPV = 0, SIG_MODE = 1, SIG_PX = 2, SIG_PY = 3, SIG_M = 4;
  localparam int SIG_A = 5, SIG_B = 6, SIG_PRIME = 7, SIG_NPV = 8, SIG_READY = 9;

  typedef struct {
    int    cyc;
    int    sig;
    logic  exp;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start;
  logic [1:0] mode;
  logic [MB-1:0] a, b, prime, Px, Py, m, nPx, nPy;
  logic ready, o_m_P_valid, o_nP_valid, o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy;
  logic i_mP_valid, i_mnP_valid, i_mPx, i_mPy, i_mnPx, i_mnPy;
  logic [MB-1:0] mPx, mPy, mnPx, mnPy;
  logic mP_done, mnP_done, err;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int mp_done_cnt = 0;
  int t_acc = 0;
  logic [9:0] tr [0:45];
  vec_t vecs [0:23];
  int nvec = 0;

  ecc_host_link #(.MAX_BITS(MB), .NP_GAP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .a(a), .b(b), .prime(prime), .Px(Px), .Py(Py), .m(m), .nPx(nPx), .nPy(nPy),
    .ready(ready), .o_m_P_valid(o_m_P_valid), .o_nP_valid(o_nP_valid),
    .o_mode(o_mode), .o_a(o_a), .o_b(o_b), .o_prime(o_prime),
    .o_Px(o_Px), .o_Py(o_Py), .o_m(o_m), .o_nPx(o_nPx), .o_nPy(o_nPy),
    .i_mP_valid(i_mP_valid), .i_mnP_valid(i_mnP_valid),
    .i_mPx(i_mPx), .i_mPy(i_mPy), .i_mnPx(i_mnPx), .i_mnPy(i_mnPy),
    .mPx(mPx), .mPy(mPy), .mnPx(mnPx), .mnPy(mnPy),
    .mP_done(mP_done), .mnP_done(mnP_done), .err(err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter and mP done-pulse counter
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (mP_done) mp_done_cnt <= mp_done_cnt + 1;
  end

  task automatic check(input string nm, input logic [MB-1:0] act, input logic [MB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input int c, input int s, input logic e, input string n);
    vecs[nvec] = '{c, s, e, n};
    nvec++;
  endtask

  // Starts a transaction; on return we sit 1 time unit after accept edge t
  task automatic do_start(input logic [1:0] md);
    start = 1'b1;
    mode  = md;
    @(posedge clk); #1;
    t_acc = cycle;
    start = 1'b0;
  endtask

  // Drives result streams, bit [31-k] on the k-th valid cycle
  task automatic send_res(input logic use_mp, input logic use_mnp,
                          input logic [31:0] x1, input logic [31:0] y1,
                          input logic [31:0] x2, input logic [31:0] y2, input int n);
    for (int k = 0; k < n; k++) begin
      i_mP_valid  = use_mp;
      i_mPx       = use_mp & x1[31-k];
      i_mPy       = use_mp & y1[31-k];
      i_mnP_valid = use_mnp;
      i_mnPx      = use_mnp & x2[31-k];
      i_mnPy      = use_mnp & y2[31-k];
      @(posedge clk); #1;
    end
    i_mP_valid = 1'b0; i_mPx = 1'b0; i_mPy = 1'b0;
    i_mnP_valid = 1'b0; i_mnPx = 1'b0; i_mnPy = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: ready still %0b after %0d cycles, required 1", nm, ready, n);
    end
  endtask

  initial begin
    int base, first, last, ones;
    logic md2, md3, px4, px5;

    rst = 1'b1; start = 1'b0; mode = '0;
    a = '0; b = '0; prime = '0; Px = '0; Py = '0; m = '0; nPx = '0; nPy = '0;
    i_mP_valid = 1'b0; i_mnP_valid = 1'b0;
    i_mPx = 1'b0; i_mPy = 1'b0; i_mnPx = 1'b0; i_mnPy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_ready", MB'(ready), MB'(1));
    check("reset_mpv", MB'(o_m_P_valid), '0);
    check("reset_px", MB'(o_Px), '0);
    check("reset_mPx", mPx, '0);
    check("reset_err", MB'(err), '0);
    check("reset_done", MB'(mP_done), '0);

    // Mode-0 frame timing, captured then checked from the vector table
    Px = MB'(32'h8000_0001); Py = MB'(5); m = MB'(32'hF);
    a = MB'(2); b = MB'(3); prime = MB'(97);
    add_vec(1, SIG_MPV, 1'b1, "mpv@1");     add_vec(2, SIG_MPV, 1'b0, "mpv@2");
    add_vec(2, SIG_MODE, 1'b0, "mode@2");   add_vec(3, SIG_MODE, 1'b0, "mode@3");
    add_vec(4, SIG_PX, 1'b1, "px@4");       add_vec(5, SIG_PX, 1'b0, "px@5");
    add_vec(20, SIG_PX, 1'b0, "px@20");     add_vec(34, SIG_PX, 1'b0, "px@34");
    add_vec(35, SIG_PX, 1'b1, "px@35");     add_vec(36, SIG_PX, 1'b0, "px@36");
    add_vec(33, SIG_PY, 1'b1, "py@33");     add_vec(34, SIG_PY, 1'b0, "py@34");
    add_vec(31, SIG_M, 1'b0, "m@31");       add_vec(32, SIG_M, 1'b1, "m@32");
    add_vec(34, SIG_A, 1'b1, "a@34");       add_vec(35, SIG_A, 1'b0, "a@35");
    add_vec(34, SIG_B, 1'b1, "b@34");       add_vec(35, SIG_B, 1'b1, "b@35");
    add_vec(28, SIG_PRIME, 1'b0, "prime@28"); add_vec(29, SIG_PRIME, 1'b1, "prime@29");
    add_vec(39, SIG_NPV, 1'b0, "npv@39");   add_vec(40, SIG_NPV, 1'b1, "npv@40");
    add_vec(41, SIG_NPV, 1'b0, "npv@41");   add_vec(1, SIG_READY, 1'b0, "ready@1");

    do_start(2'd0);
    tr[0] = '0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      tr[k] = {ready, o_nP_valid, o_prime, o_b, o_a, o_m, o_Py, o_Px, o_mode, o_m_P_valid};
    end
    for (int i = 0; i < nvec; i++)
      check(vecs[i].name, MB'(tr[vecs[i].cyc][vecs[i].sig]), MB'(vecs[i].exp));

    // mP result, then mnP about 20 cycles later
    send_res(1'b1, 1'b0, 32'h1234_5678, 32'hCAFE_BABE, 32'h0, 32'h0, 32);
    @(posedge clk); #1;
    check("mp_done", MB'(mP_done), MB'(1));
    check("mpx", mPx, MB'(32'h1234_5678));
    check("mpy", mPy, MB'(32'hCAFE_BABE));
    check("mnp_done_early", MB'(mnP_done), '0);
    @(posedge clk); #1;
    check("mp_done_pulse", MB'(mP_done), '0);
    repeat (18) @(posedge clk);
    #1;
    send_res(1'b0, 1'b1, 32'h0, 32'h0, 32'h0BAD_F00D, 32'h1357_9BDF, 32);
    @(posedge clk); #1;
    check("mnp_done", MB'(mnP_done), MB'(1));
    check("mnpx", mnPx, MB'(32'h0BAD_F00D));
    check("mnpy", mnPy, MB'(32'h1357_9BDF));
    check("ready_before", MB'(ready), '0);
    @(posedge clk); #1;
    check("ready_after", MB'(ready), MB'(1));
    check("err_clean", MB'(err), '0);

    // Short frame then correct retransmit
    do_start(2'd0);
    base = mp_done_cnt;
    send_res(1'b1, 1'b0, 32'hA5A5_0000, 32'h5A5A_FFFF, 32'h0, 32'h0, 10);
    @(posedge clk); #1;
    check("short_err", MB'(err), MB'(1));
    check("short_no_done", MB'(mp_done_cnt - base), '0);
    send_res(1'b1, 1'b0, 32'h8000_0003, 32'h7FFF_FFFE, 32'h0, 32'h0, 32);
    @(posedge clk); #1;
    check("retx_done", MB'(mP_done), MB'(1));
    check("retx_mpx", mPx, MB'(32'h8000_0003));
    check("retx_mpy", mPy, MB'(32'h7FFF_FFFE));
    check("err_sticky", MB'(err), MB'(1));
    send_res(1'b0, 1'b1, 32'h0, 32'h0, 32'h1, 32'h2, 32);
    wait_ready("short_ready");

    // Reset mid-DATA, then a clean transaction with overlapping results
    Px = '1;
    do_start(2'd0);
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_px", MB'(o_Px), MB'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_ready", MB'(ready), MB'(1));
    check("rst_serial", MB'({o_mode, o_a, o_b, o_prime, o_Px, o_Py, o_m, o_nPx, o_nPy,
                             o_m_P_valid, o_nP_valid}), '0);
    do_start(2'd0);
    check("new_err_clear", MB'(err), '0);
    @(posedge clk); #1;
    check("new_mpv", MB'(o_m_P_valid), MB'(1));
    repeat (3) @(posedge clk);
    #1;
    check("new_px", MB'(o_Px), MB'(1));
    send_res(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32);
    @(posedge clk); #1;
    check("ovl_mp_done", MB'(mP_done), MB'(1));
    check("ovl_mnp_done", MB'(mnP_done), MB'(1));
    check("ovl_mpx", mPx, MB'(32'hDEAD_BEEF));
    check("ovl_mpy", mPy, MB'(32'h0123_4567));
    check("ovl_mnpx", mnPx, MB'(32'h89AB_CDEF));
    check("ovl_mnpy", mnPy, MB'(32'hFEDC_BA98));
    wait_ready("ovl_ready");
    check("ovl_ready_cycle", MB'(cycle - t_acc), MB'(73));
    check("ovl_err", MB'(err), '0);

    // Mode 3: full-width frame, nPx all ones
    Px = '0; Px[MB-1] = 1'b1; nPx = '1; nPy = '0;
    do_start(2'd3);
    first = -1; last = -1; ones = 0;
    md2 = 1'b0; md3 = 1'b0; px4 = 1'b0; px5 = 1'b0;
    for (int k = 1; k <= 530; k++) begin
      @(posedge clk); #1;
      if (k == 2) md2 = o_mode;
      if (k == 3) md3 = o_mode;
      if (k == 4) px4 = o_Px;
      if (k == 5) px5 = o_Px;
      if (o_nPx) begin
        if (first < 0) first = k;
        last = k;
        ones++;
      end
    end
    check("m3_mode2", MB'(md2), MB'(1));
    check("m3_mode3", MB'(md3), MB'(1));
    check("m3_px4", MB'(px4), MB'(1));
    check("m3_px5", MB'(px5), '0);
    check("m3_npx_first", MB'(first), MB'(265));
    check("m3_npx_last", MB'(last), MB'(520));
    check("m3_npx_count", MB'(ones), MB'(256));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
